timer_irq_dev: RTL and testbench

//  Memory-mapped countdown timer on the CPU bridge; interrupt source driving one HWInt[5:0] line into CP0.

---
 rtl/timer_irq_dev_if.sv | 14 +
 rtl/timer_irq_dev.sv | 149 ++++++++++++++
 tb/tb_timer_irq_dev.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_irq_dev_if.sv
// Bus bundle between the CPU bridge (master) and the countdown timer (slave).
// Protocol: no valid/ready pair. A write is a single cycle with we=1, and it is
// accepted on that posedge. A read has no wait states: dout follows addr
// combinationally. irq is a level signal.
interface timer_irq_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer that drives one HWInt line into CP0.
// Register map (word select): 0 CTRL {IM,MODE[1:0],EN}, 1 PRESET, 2 COUNT (read-only), 3 reads 0.
// Mode 1 auto-reloads (periodic). Every other mode value is one-shot.
// Optional feature macro TIMER_PRESCALE_EN: the count only steps once every PRESCALE cycles.
// dbg_state_o exposes the FSM state for observation.
module timer_irq_dev #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_irq_dev_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  // A prescaler of zero would never produce a tick, so reject it at elaboration.
  if (PRESCALE < 1) begin : g_prescale_chk
    $error("timer_irq_dev: PRESCALE must be >= 1");
  end

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        tick;

  wire ctrl_en    = ctrl_q[0];
  wire ctrl_im    = ctrl_q[3];
  wire periodic   = (ctrl_q[2:1] == 2'd1);
  wire wr_ctrl    = bus.we && (bus.addr == 2'd0);
  wire wr_preset  = bus.we && (bus.addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_q, psc_d;

  // Prescale counter: restarts on LOAD, advances only while actively counting.
  always_comb begin
    psc_d = psc_q;
    tick  = (psc_q == PSC_MAX);
    if (state_q == S_LOAD) begin
      psc_d = '0;
    end else if (state_q == S_CNT && ctrl_en) begin
      psc_d = tick ? '0 : psc_q + 1'b1;
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) psc_q <= '0;
    else        psc_q <= psc_d;
  end
`else
  // Without prescaling the count steps every cycle.
  always_comb begin
    tick = 1'b1;
  end
`endif

  // Next-state and register updates. Bus writes are applied last so that
  // software wins over FSM side effects (EN auto-clear, flag set).
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (count_q == 32'd0) begin
            state_d = S_INT;
            flag_d  = 1'b1;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      S_INT: begin
        if (periodic) begin
          flag_d  = 1'b0;
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_ctrl) begin
      ctrl_d = bus.din[3:0];
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = bus.din;
      flag_d   = 1'b0;
    end
  end

  // State and register file, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Read mux and interrupt output. The flag is tracked even while IM masks it.
  always_comb begin
    case (bus.addr)
      2'd0:    bus.dout = {28'd0, ctrl_q};
      2'd1:    bus.dout = preset_q;
      2'd2:    bus.dout = count_q;
      default: bus.dout = 32'd0;
    endcase
    bus.irq     = ctrl_im & flag_q;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_timer_irq_dev.sv
// Bench for timer_irq_dev: directed scenarios with literal expectations and a
// randomized run, all checked every cycle against a timeline-based model.
module tb_timer_irq_dev;

`ifdef TIMER_PRESCALE_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] dbg_state;

  timer_irq_dev_if bus();

  timer_irq_dev #(.PRESCALE(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          chk_on   = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The timer is described as a timeline. After EN is seen, one edge arms the run
  // and the next edge loads L = PRESET. Each further enabled edge is one elapsed
  // cycle c. The visible count is L - c/P. The run expires on the edge where
  // c/P first exceeds L. The edge after that is the expiry reaction.
  localparam int PH_IDLE = 0, PH_ARM = 1, PH_RUN = 2, PH_EXP = 3;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_L;
  logic        m_flag;
  int          m_ph;
  longint      m_c;

  task automatic model_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_L = 32'd0;
    m_flag = 1'b0; m_ph = PH_IDLE; m_c = 0;
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_preset, n_count;
    logic        n_flag;
    int          n_ph;
    longint      n_c;
    n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count;
    n_flag = m_flag; n_ph = m_ph; n_c = m_c;
    if (m_ph == PH_IDLE) begin
      if (m_ctrl[0]) n_ph = PH_ARM;
    end else if (m_ph == PH_ARM) begin
      m_L = m_preset; n_count = m_preset; n_c = 0; n_ph = PH_RUN;
    end else if (m_ph == PH_RUN) begin
      if (!m_ctrl[0]) n_ph = PH_IDLE;
      else begin
        n_c = m_c + 1;
        if (n_c / P > longint'(m_L)) begin
          n_ph = PH_EXP; n_flag = 1'b1;
        end else begin
          n_count = m_L - 32'(n_c / P);
        end
      end
    end else begin
      if (m_ctrl[2:1] == 2'd1) begin
        n_flag = 1'b0; n_ph = PH_ARM;
      end else begin
        n_ctrl[0] = 1'b0; n_ph = PH_IDLE;
      end
    end
    if (w && a == 2'd0) begin n_ctrl = d[3:0]; n_flag = 1'b0; end
    if (w && a == 2'd1) begin n_preset = d; n_flag = 1'b0; end
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count;
    m_flag = n_flag; m_ph = n_ph; m_c = n_c;
  endtask

  function automatic logic [31:0] model_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_on && reset) begin
      check("irq_model",  {31'd0, bus.irq}, {31'd0, m_flag & m_ctrl[3]});
      check("dout_model", bus.dout, model_dout(bus.addr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d);
    bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk);
    if (reset) model_edge(w, a, d);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) step(1'b0, a, 32'd0);
  endtask

  task automatic read_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.we = 1'b0; bus.addr = a;
    #1;
    check(name, bus.dout, exp);
  endtask

  task automatic irq_chk(input logic exp, input string name);
    check(name, {31'd0, bus.irq}, {31'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    irq_chk(1'b0, "reset_irq_async");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] d;
    int r;
    bus.we = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    chk_on = 1'b1;
    #1;

    // Reset values on every address.
    for (int a = 0; a < 4; a++) read_chk(2'(a), 32'd0, "reset_dout");
    irq_chk(1'b0, "reset_irq");

`ifndef TIMER_PRESCALE_EN
    // One-shot, PRESET=3: irq rises after edge e0+6.
    step(1'b1, 2'd1, 32'd3);
    step(1'b1, 2'd0, 32'h9);
    idle(5, 2'd2);
    irq_chk(1'b0, "oneshot_irq_early");
    idle(1, 2'd2);
    irq_chk(1'b1, "oneshot_irq_rise");
    idle(1, 2'd0);
    read_chk(2'd0, 32'h8, "oneshot_ctrl_en_cleared");
    read_chk(2'd2, 32'd0, "oneshot_count_zero");
    idle(3, 2'd2);
    irq_chk(1'b1, "oneshot_irq_held");
    step(1'b1, 2'd1, 32'd5);
    irq_chk(1'b0, "oneshot_irq_cleared_by_preset");

    // Periodic, PRESET=2: 1-cycle pulses every 5 edges, COUNT 2,1,0,0,0.
    step(1'b1, 2'd1, 32'd2);
    step(1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      case (k % 5)
        2: exp_q.push_back(32'd2);
        3: exp_q.push_back(32'd1);
        default: exp_q.push_back(32'd0);
      endcase
    end
    for (int k = 1; k <= 15; k++) begin
      idle(1, 2'd2);
      irq_chk((k % 5) == 0, "periodic_irq");
      check("periodic_count", bus.dout, exp_q.pop_front());
    end
    step(1'b1, 2'd0, 32'h0);

    // EN cleared mid-count holds COUNT, re-enable reloads.
    step(1'b1, 2'd1, 32'd10);
    step(1'b1, 2'd0, 32'h1);
    idle(5, 2'd2);
    read_chk(2'd2, 32'd7, "pause_count_before");
    step(1'b1, 2'd0, 32'h0);
    idle(4, 2'd2);
    read_chk(2'd2, 32'd6, "pause_count_frozen");
    irq_chk(1'b0, "pause_no_irq");
    step(1'b1, 2'd0, 32'h1);
    idle(2, 2'd2);
    read_chk(2'd2, 32'd10, "pause_count_reloaded");
    step(1'b1, 2'd0, 32'h0);

    // IM=0 masks the interrupt; a CTRL write then clears the flag.
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h1);
    for (int k = 0; k < 8; k++) begin
      idle(1, 2'd2);
      irq_chk(1'b0, "masked_irq_low");
    end
    read_chk(2'd0, 32'h0, "masked_en_cleared");
    step(1'b1, 2'd0, 32'h8);
    idle(3, 2'd0);
    irq_chk(1'b0, "masked_flag_cleared");

    // COUNT is read-only.
    step(1'b1, 2'd2, 32'hDEAD_BEEF);
    read_chk(2'd2, 32'd0, "count_readonly");

    // Reset while irq is high and while counting.
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h9);
    idle(4, 2'd2);
    irq_chk(1'b1, "pre_reset_irq");
    do_reset();
    read_chk(2'd0, 32'd0, "post_reset_ctrl");
    step(1'b1, 2'd1, 32'd20);
    step(1'b1, 2'd0, 32'h9);
    idle(5, 2'd2);
    read_chk(2'd2, 32'd17, "mid_count_value");
    do_reset();
    read_chk(2'd2, 32'd0, "mid_count_reset");
`else
    // Prescaled one-shot, PRESET=1: irq after edge e0+10.
    step(1'b1, 2'd1, 32'd1);
    step(1'b1, 2'd0, 32'h9);
    idle(9, 2'd2);
    irq_chk(1'b0, "psc_irq_early");
    idle(1, 2'd2);
    irq_chk(1'b1, "psc_irq_rise");
    step(1'b1, 2'd1, 32'd6);
    step(1'b1, 2'd0, 32'h9);
    idle(8, 2'd2);
    do_reset();
    read_chk(2'd2, 32'd0, "psc_reset_count");
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 299);
      if (r == 0) begin
        do_reset();
      end else if (r < 24) begin
        d = $urandom();
        d[0] = ($urandom_range(0, 3) != 0);
        step(1'b1, 2'd0, d);
      end else if (r < 42) begin
        d = $urandom_range(0, 6);
        if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 40);
        step(1'b1, 2'd1, d);
      end else if (r < 50) begin
        step(1'b1, 2'($urandom_range(2, 3)), $urandom());
      end else begin
        step(1'b0, 2'($urandom_range(0, 3)), $urandom());
      end
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
